// File: rtl/pwm_multi_if.sv
// rtl/pwm_multi_if.sv - configuration handshake bundle for pwm_multi
interface pwm_multi_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0]    cfg_period;
  logic [CH*CNT_W-1:0] cfg_duty;
  logic                cfg_valid;
  logic                cfg_ready;

  modport master (
    output cfg_period,
    output cfg_duty,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_period,
    input  cfg_duty,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM, shared period counter, double-buffered config
module pwm_multi #(
  parameter int CH    = 4,
  parameter int CNT_W = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          pwm_en,
  pwm_multi_if.slave    cfg,
  output logic [CH-1:0] pwm_out,
  output logic          period_tick
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            per_act_q, per_act_d;
  logic [CH-1:0][CNT_W-1:0]    duty_act_q, duty_act_d;
  logic [CNT_W-1:0]            per_pend_q, per_pend_d;
  logic [CH-1:0][CNT_W-1:0]    duty_pend_q, duty_pend_d;
  logic                        pend_q, pend_d;
  logic [CH-1:0]               pwm_q, pwm_d;
  logic                        tick_q, tick_d;
  logic                        running;
  logic                        at_end;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      per_act_q   <= '0;
      duty_act_q  <= '0;
      per_pend_q  <= '0;
      duty_pend_q <= '0;
      pend_q      <= 1'b0;
      pwm_q       <= '0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_act_q   <= per_act_d;
      duty_act_q  <= duty_act_d;
      per_pend_q  <= per_pend_d;
      duty_pend_q <= duty_pend_d;
      pend_q      <= pend_d;
      pwm_q       <= pwm_d;
      tick_q      <= tick_d;
    end
  end

  always_comb begin
    state_d     = pwm_en ? RUN : IDLE;
    per_act_d   = per_act_q;
    duty_act_d  = duty_act_q;
    per_pend_d  = per_pend_q;
    duty_pend_d = duty_pend_q;
    pend_d      = pend_q;
    running     = (state_q == RUN);
    at_end      = running && (cnt_q == per_act_q);

    // Wrap decision uses the period that is active now, before any swap.
    if (!running || at_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    tick_d = at_end;
    for (int i = 0; i < CH; i++) begin
      pwm_d[i] = running && (cnt_q < duty_act_q[i]);
    end

    // Accept and apply are mutually exclusive on pend_q, so a capture on a
    // boundary edge waits for the following boundary.
    if (pend_q) begin
      if (!running || at_end) begin
        per_act_d  = per_pend_q;
        duty_act_d = duty_pend_q;
        pend_d     = 1'b0;
      end
    end else if (cfg.cfg_valid) begin
      per_pend_d  = cfg.cfg_period;
      duty_pend_d = cfg.cfg_duty;
      pend_d      = 1'b1;
    end
  end

  assign cfg.cfg_ready = !pend_q;
  assign pwm_out       = pwm_q;
  assign period_tick   = tick_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi with a period-level reference model
module tb_pwm_multi;
  localparam int CH    = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [31:0]         per;
    logic [CH-1:0][31:0] duty;
  } cfg_t;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          pwm_en;
  logic [CH-1:0] pwm_out;
  logic          period_tick;

  pwm_multi_if #(.CH(CH), .CNT_W(CNT_W)) cfg_if ();

  pwm_multi #(.CH(CH), .CNT_W(CNT_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .pwm_en      (pwm_en),
    .cfg         (cfg_if.slave),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference model: where are we inside the current period, which config is
  // in force, and which one is queued behind it.
  bit            m_run;
  int            m_pos;
  cfg_t          m_act;
  cfg_t          m_pend[$];
  cfg_t          m_new;
  bit            m_end;
  logic [CH-1:0] e_out;
  bit            e_tick;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_run  = 1'b0;
      m_pos  = 0;
      m_act  = '0;
      m_pend.delete();
      e_out  = '0;
      e_tick = 1'b0;
    end else begin
      m_end  = m_run && (m_pos == int'(m_act.per));
      e_tick = m_end;
      for (int i = 0; i < CH; i++) e_out[i] = m_run && (m_pos < int'(m_act.duty[i]));
      if (m_pend.size() != 0) begin
        if (!m_run || m_end) m_act = m_pend.pop_front();
      end else if (cfg_if.cfg_valid) begin
        m_new.per = 32'(cfg_if.cfg_period);
        for (int i = 0; i < CH; i++) m_new.duty[i] = 32'(cfg_if.cfg_duty[i*CNT_W +: CNT_W]);
        m_pend.push_back(m_new);
      end
      m_pos = (!m_run || m_end) ? 0 : m_pos + 1;
      m_run = pwm_en;
    end
    #1;
    check("pwm_out", 32'(pwm_out), 32'(e_out));
    check("period_tick", 32'(period_tick), 32'(e_tick));
    check("cfg_ready", 32'(cfg_if.cfg_ready), (m_pend.size() == 0) ? 32'd1 : 32'd0);
  end

  int cnt_hi[CH];
  int cnt_tick;

  task automatic count_cycles(input int n);
    for (int i = 0; i < CH; i++) cnt_hi[i] = 0;
    cnt_tick = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      for (int i = 0; i < CH; i++) cnt_hi[i] += int'(pwm_out[i]);
      cnt_tick += int'(period_tick);
    end
  endtask

  task automatic send_cfg(input logic [7:0] per, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    bit got = 1'b0;
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_period = per;
    cfg_if.cfg_duty   = {d3, d2, d1, d0};
    for (int k = 0; k < 200; k++) begin
      if (cfg_if.cfg_ready) begin
        @(posedge sys_clk);
        got = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    if (!got) timeout("send_cfg");
    @(negedge sys_clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_next_tick();
    for (int k = 0; k < 300; k++) begin
      @(negedge sys_clk);
      if (e_tick) return;
    end
    timeout("wait_next_tick");
  endtask

  task automatic wait_pos(input int p);
    for (int k = 0; k < 300; k++) begin
      @(negedge sys_clk);
      if (m_run && m_pos == p) return;
    end
    timeout("wait_pos");
  endtask

  initial begin
    sys_rst           = 1'b1;
    pwm_en            = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_duty   = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_pwm_out", 32'(pwm_out), 32'd0);
    check("rst_tick", 32'(period_tick), 32'd0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    sys_rst = 1'b0;

    // Basic duty: period 10, duties 0/3/10/255.
    send_cfg(8'd9, 8'd0, 8'd3, 8'd10, 8'd255);
    pwm_en = 1'b1;
    wait_next_tick();
    count_cycles(10);
    check("basic_ch0", cnt_hi[0], 0);
    check("basic_ch1", cnt_hi[1], 3);
    check("basic_ch2", cnt_hi[2], 10);
    check("basic_ch3", cnt_hi[3], 10);
    check("basic_tick", cnt_tick, 1);

    // Mid-period update takes effect only after the wrap.
    wait_pos(4);
    send_cfg(8'd9, 8'd0, 8'd7, 8'd10, 8'd255);
    check("upd_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    wait_next_tick();
    check("upd_ready_high", 32'(cfg_if.cfg_ready), 32'd1);
    count_cycles(10);
    check("upd_ch1", cnt_hi[1], 7);

    // Transfer on the boundary edge is deferred a whole period.
    wait_pos(9);
    send_cfg(8'd9, 8'd0, 8'd5, 8'd10, 8'd255);
    count_cycles(10);
    check("coll_old_ch1", cnt_hi[1], 7);
    count_cycles(10);
    check("coll_new_ch1", cnt_hi[1], 5);

    // Back-pressure: second config held until the first is applied.
    send_cfg(8'd9, 8'd0, 8'd2, 8'd10, 8'd255);
    check("bp_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    send_cfg(8'd9, 8'd1, 8'd6, 8'd4, 8'd8);
    wait_next_tick();
    count_cycles(10);
    check("bp_ch0", cnt_hi[0], 1);
    check("bp_ch1", cnt_hi[1], 6);
    check("bp_ch3", cnt_hi[3], 8);

    // Disable mid-period, reconfigure while idle, re-enable.
    wait_pos(5);
    pwm_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("dis_pwm_out", 32'(pwm_out), 32'd0);
    send_cfg(8'd4, 8'd1, 8'd2, 8'd3, 8'd4);
    check("idle_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    @(negedge sys_clk);
    check("idle_ready_high", 32'(cfg_if.cfg_ready), 32'd1);
    pwm_en = 1'b1;
    @(negedge sys_clk);
    check("reen_first_out", 32'(pwm_out), 32'd0);
    count_cycles(5);
    check("reen_ch0", cnt_hi[0], 1);
    check("reen_ch1", cnt_hi[1], 2);
    check("reen_ch2", cnt_hi[2], 3);
    check("reen_ch3", cnt_hi[3], 4);
    check("reen_tick", cnt_tick, 1);

    // Reset with a pending config discards it.
    wait_pos(1);
    send_cfg(8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst2_pwm_out", 32'(pwm_out), 32'd0);
    check("rst2_tick", 32'(period_tick), 32'd0);
    check("rst2_ready", 32'(cfg_if.cfg_ready), 32'd1);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    count_cycles(6);
    check("rst2_no_pending", cnt_hi[0], 0);
    check("rst2_tick_every", cnt_tick, 6);

    // Degenerate one-cycle period.
    send_cfg(8'd0, 8'd1, 8'd1, 8'd1, 8'd1);
    repeat (2) @(negedge sys_clk);
    count_cycles(8);
    check("deg_ch0", cnt_hi[0], 8);
    check("deg_ch3", cnt_hi[3], 8);
    check("deg_tick", cnt_tick, 8);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      @(negedge sys_clk);
      if (!(cfg_if.cfg_valid && !cfg_if.cfg_ready)) begin
        cfg_if.cfg_valid  = ($urandom_range(0, 3) == 0);
        cfg_if.cfg_period = 8'($urandom_range(0, 12));
        for (int i = 0; i < CH; i++) cfg_if.cfg_duty[i*CNT_W +: CNT_W] = 8'($urandom_range(0, 14));
      end
      pwm_en  = ($urandom_range(0, 19) != 0);
      sys_rst = ($urandom_range(0, 149) == 0);
    end
    sys_rst = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    repeat (4) @(negedge sys_clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
